// File: rtl/hisoc_test_seq.sv
`default_nettype none
// ============================================================================
// hisoc_test_seq : loads, resets, runs and scores a sequence of HISOC tests
// Rev 1.0
// ============================================================================
module hisoc_test_seq #(
  parameter int TEST_NUM     = 37,
  parameter int CPU_WIDTH    = 32,
  parameter int RST_CYC      = 1,
  parameter int EN_DLY       = 5,
  parameter int SETTLE_CYC   = 4,
  parameter int TIMEOUT_CYC  = 2000,
  parameter int STOP_ON_FAIL = 1,
  parameter int ID_W         = (TEST_NUM > 1) ? $clog2(TEST_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CPU_WIDTH-1:0] done_reg,
  input  logic [CPU_WIDTH-1:0] pass_reg,
  input  logic [CPU_WIDTH-1:0] testnum_reg,
  output logic                 load_req,
  output logic [ID_W-1:0]      load_id,
  input  logic                 load_ack,
  output logic                 dut_rst_n,
  output logic                 dut_enable,
  output logic                 busy,
  output logic                 all_done,
  output logic [ID_W:0]        pass_cnt,
  output logic [ID_W:0]        fail_cnt,
  output logic [ID_W:0]        timeout_cnt,
  output logic                 fail_valid,
  output logic [ID_W-1:0]      fail_id,
  output logic [CPU_WIDTH-1:0] fail_testnum,
  output logic                 fail_timeout
);

  localparam int C_MAX_A   = (RST_CYC > EN_DLY) ? RST_CYC : EN_DLY;
  localparam int C_MAX_B   = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int C_MAX_CYC = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int CNT_W     = $clog2(C_MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RESET, S_DELAY, S_RUN, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 pass_q, pass_d;
  logic [CPU_WIDTH-1:0] tnum_q, tnum_d;
  logic [ID_W-1:0]      id_d;
  logic                 w_launch;
  logic                 w_bad;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pass_d   = pass_q;
    tnum_d   = tnum_q;
    id_d     = load_id;
    w_launch = 1'b0;
    w_bad    = tmo_q || !pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          id_d     = '0;
          w_launch = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_ack) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == CNT_W'(EN_DLY - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (done_reg == CPU_WIDTH'(1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_CHECK;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        // Core results are captured before CHECK puts the core back in reset.
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = S_CHECK;
          tmo_d   = 1'b0;
          pass_d  = (pass_reg == CPU_WIDTH'(1));
          tnum_d  = testnum_reg;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (w_bad && (STOP_ON_FAIL != 0)) begin
          state_d = S_DONE;
        end else if (load_id == ID_W'(TEST_NUM - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          id_d    = load_id + ID_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
      pass_q       <= 1'b0;
      tnum_q       <= '0;
      load_id      <= '0;
      load_req     <= 1'b0;
      dut_rst_n    <= 1'b0;
      dut_enable   <= 1'b0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      timeout_cnt  <= '0;
      fail_valid   <= 1'b0;
      fail_id      <= '0;
      fail_testnum <= '0;
      fail_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pass_q     <= pass_d;
      tnum_q     <= tnum_d;
      load_id    <= id_d;
      load_req   <= (state_d == S_LOAD);
      dut_rst_n  <= (state_d == S_DELAY) || (state_d == S_RUN) || (state_d == S_SETTLE);
      dut_enable <= (state_d == S_RUN) || (state_d == S_SETTLE);
      busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
      all_done   <= (state_d == S_DONE);
      fail_valid <= 1'b0;
      if (w_launch) begin
        pass_cnt     <= '0;
        fail_cnt     <= '0;
        timeout_cnt  <= '0;
        fail_id      <= '0;
        fail_testnum <= '0;
        fail_timeout <= 1'b0;
      end else if (state_q == S_CHECK) begin
        if (tmo_q) begin
          timeout_cnt  <= timeout_cnt + (ID_W+1)'(1);
          fail_valid   <= 1'b1;
          fail_id      <= load_id;
          fail_testnum <= '1;
          fail_timeout <= 1'b1;
        end else if (pass_q) begin
          pass_cnt <= pass_cnt + (ID_W+1)'(1);
        end else begin
          fail_cnt     <= fail_cnt + (ID_W+1)'(1);
          fail_valid   <= 1'b1;
          fail_id      <= load_id;
          fail_testnum <= tnum_q;
          fail_timeout <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hisoc_test_seq.sv
`default_nettype none
// Bench: two sequencers (run-all and stop-on-fail) driven by a scripted core
// model; expected statistics come from per-test outcome bookkeeping.
module tb_hisoc_test_seq;
  localparam int TN    = 3;
  localparam int IDW   = 2;
  localparam int CW    = 32;
  localparam int TMO   = 20;
  localparam int ENDLY = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic          ack_s   [2];
  logic [CW-1:0] done_s  [2];
  logic [CW-1:0] pass_s  [2];
  logic [CW-1:0] gp_s    [2];
  logic          lreq_s  [2];
  logic [IDW-1:0] lid_s  [2];
  logic          rstn_s  [2];
  logic          en_s    [2];
  logic          busy_s  [2];
  logic          alld_s  [2];
  logic [IDW:0]  pcnt_s  [2];
  logic [IDW:0]  fcnt_s  [2];
  logic [IDW:0]  tcnt_s  [2];
  logic          fv_s    [2];
  logic [IDW-1:0] fid_s  [2];
  logic [CW-1:0] ftn_s   [2];
  logic          fto_s   [2];

  hisoc_test_seq #(.TEST_NUM(TN), .CPU_WIDTH(CW), .RST_CYC(1), .EN_DLY(ENDLY),
                   .SETTLE_CYC(4), .TIMEOUT_CYC(TMO), .STOP_ON_FAIL(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .done_reg(done_s[0]),
    .pass_reg(pass_s[0]), .testnum_reg(gp_s[0]), .load_req(lreq_s[0]),
    .load_id(lid_s[0]), .load_ack(ack_s[0]), .dut_rst_n(rstn_s[0]),
    .dut_enable(en_s[0]), .busy(busy_s[0]), .all_done(alld_s[0]),
    .pass_cnt(pcnt_s[0]), .fail_cnt(fcnt_s[0]), .timeout_cnt(tcnt_s[0]),
    .fail_valid(fv_s[0]), .fail_id(fid_s[0]), .fail_testnum(ftn_s[0]),
    .fail_timeout(fto_s[0])
  );

  hisoc_test_seq #(.TEST_NUM(TN), .CPU_WIDTH(CW), .RST_CYC(1), .EN_DLY(ENDLY),
                   .SETTLE_CYC(4), .TIMEOUT_CYC(TMO), .STOP_ON_FAIL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .done_reg(done_s[1]),
    .pass_reg(pass_s[1]), .testnum_reg(gp_s[1]), .load_req(lreq_s[1]),
    .load_id(lid_s[1]), .load_ack(ack_s[1]), .dut_rst_n(rstn_s[1]),
    .dut_enable(en_s[1]), .busy(busy_s[1]), .all_done(alld_s[1]),
    .pass_cnt(pcnt_s[1]), .fail_cnt(fcnt_s[1]), .timeout_cnt(tcnt_s[1]),
    .fail_valid(fv_s[1]), .fail_id(fid_s[1]), .fail_testnum(ftn_s[1]),
    .fail_timeout(fto_s[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference statistics per instance
  int            m_pass [2];
  int            m_fail [2];
  int            m_tmo  [2];
  int            m_fid  [2];
  logic [CW-1:0] m_ftn  [2];
  bit            m_fto  [2];

  // Per-test plan: ack delay, RUN cycle of done (0 = never), pass, gp value
  int            p_ack  [TN];
  int            p_done [TN];
  bit            p_pass [TN];
  logic [CW-1:0] p_gp   [TN];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int inst);
    chk("rst_load_req", lreq_s[inst], 0);
    chk("rst_load_id", lid_s[inst], 0);
    chk("rst_dut_rst_n", rstn_s[inst], 0);
    chk("rst_enable", en_s[inst], 0);
    chk("rst_busy", busy_s[inst], 0);
    chk("rst_all_done", alld_s[inst], 0);
    chk("rst_pass_cnt", pcnt_s[inst], 0);
    chk("rst_fail_cnt", fcnt_s[inst], 0);
    chk("rst_tmo_cnt", tcnt_s[inst], 0);
    chk("rst_fail_valid", fv_s[inst], 0);
    chk("rst_fail_id", fid_s[inst], 0);
    chk("rst_fail_testnum", ftn_s[inst], 0);
    chk("rst_fail_timeout", fto_s[inst], 0);
  endtask

  task automatic do_start(input int inst);
    m_pass[inst] = 0; m_fail[inst] = 0; m_tmo[inst] = 0;
    m_fid[inst] = 0; m_ftn[inst] = '0; m_fto[inst] = 1'b0;
    start_s[inst] = 1'b1;
    tick();
    start_s[inst] = 1'b0;
    chk("start_busy", busy_s[inst], 1);
    chk("start_all_done", alld_s[inst], 0);
    chk("start_fail_cnt", fcnt_s[inst], 0);
    chk("start_tmo_cnt", tcnt_s[inst], 0);
    chk("start_pass_cnt", pcnt_s[inst], 0);
    chk("start_fail_testnum", ftn_s[inst], 0);
    chk("start_fail_timeout", fto_s[inst], 0);
  endtask

  // disturb: 0 none, 1 start pulse in RUN, 2 async reset in RUN (aborts)
  task automatic do_test(input int inst, input int t, input int ack_dly, input int done_at,
                         input bit pas, input logic [CW-1:0] gp, input bit stop,
                         input int disturb, output bit last);
    bit is_to, is_pass, exp_fv;
    last    = 1'b0;
    is_to   = !(done_at >= 1 && done_at <= TMO);
    is_pass = !is_to && pas;
    chk("load_req_on", lreq_s[inst], 1);
    chk("load_id", lid_s[inst], t);
    for (int i = 0; i < ack_dly; i++) tick();
    chk("load_req_hold", lreq_s[inst], 1);
    chk("fail_valid_pulse", fv_s[inst], 0);
    chk("rstn_in_load", rstn_s[inst], 0);
    ack_s[inst] = 1'b1;
    tick();
    ack_s[inst] = 1'b0;
    chk("ack_req_drop", lreq_s[inst], 0);
    chk("ack_rstn_low", rstn_s[inst], 0);
    tick();
    chk("rstn_rise", rstn_s[inst], 1);
    chk("en_low_at_rstn", en_s[inst], 0);
    for (int i = 1; i < ENDLY; i++) tick();
    chk("en_still_low", en_s[inst], 0);
    tick();
    chk("en_rise", en_s[inst], 1);
    for (int k = 1; k <= TMO; k++) begin
      if (disturb == 2 && k == 5) begin
        #2 rst = 1'b1;
        #1;
        chk_all_zero(inst);
        last = 1'b1;
        return;
      end
      if (disturb == 1 && k == 3) start_s[inst] = 1'b1;
      // done_reg must equal exactly 1; a value of 3 is not completion
      done_s[inst] = (k == done_at) ? 32'd1 : ((k == 2) ? 32'd3 : 32'd0);
      if (k == done_at) begin
        pass_s[inst] = pas ? 32'd1 : ((t % 2 == 0) ? 32'd0 : 32'd3);
        gp_s[inst]   = gp;
      end
      tick();
      if (disturb == 1 && k == 3) begin
        start_s[inst] = 1'b0;
        chk("busy_start_en", en_s[inst], 1);
        chk("busy_start_req", lreq_s[inst], 0);
        chk("busy_start_id", lid_s[inst], t);
      end
      if (is_to && k == TMO - 1) chk("run_before_tmo", en_s[inst], 1);
      if (k == done_at) break;
    end
    if (!is_to) begin
      chk("settle_en", en_s[inst], 1);
      for (int i = 0; i < 3; i++) tick();
      chk("settle_en_end", en_s[inst], 1);
      tick();
    end
    chk("check_en_low", en_s[inst], 0);
    chk("check_rstn_low", rstn_s[inst], 0);
    tick();
    done_s[inst] = '0; pass_s[inst] = '0; gp_s[inst] = '0;
    exp_fv = 1'b1;
    if (is_to) begin
      m_tmo[inst]++; m_fid[inst] = t; m_ftn[inst] = '1; m_fto[inst] = 1'b1;
    end else if (is_pass) begin
      m_pass[inst]++; exp_fv = 1'b0;
    end else begin
      m_fail[inst]++; m_fid[inst] = t; m_ftn[inst] = gp; m_fto[inst] = 1'b0;
    end
    chk("fail_valid", fv_s[inst], exp_fv);
    chk("pass_cnt", pcnt_s[inst], m_pass[inst]);
    chk("fail_cnt", fcnt_s[inst], m_fail[inst]);
    chk("timeout_cnt", tcnt_s[inst], m_tmo[inst]);
    chk("fail_id", fid_s[inst], m_fid[inst]);
    chk("fail_testnum", ftn_s[inst], m_ftn[inst]);
    chk("fail_timeout", fto_s[inst], m_fto[inst]);
    last = (stop && !is_pass) || (t == TN - 1);
    if (last) begin
      chk("done_all_done", alld_s[inst], 1);
      chk("done_busy", busy_s[inst], 0);
      chk("done_load_id", lid_s[inst], t);
      chk("done_rstn", rstn_s[inst], 0);
      tick();
      chk("done_fv_end", fv_s[inst], 0);
      chk("done_hold", alld_s[inst], 1);
      chk("done_hold_total", pcnt_s[inst] + fcnt_s[inst] + tcnt_s[inst],
          m_pass[inst] + m_fail[inst] + m_tmo[inst]);
    end
  endtask

  task automatic run_seq(input int inst, input int dis_t, input int dis_kind);
    bit last;
    do_start(inst);
    for (int t = 0; t < TN; t++) begin
      do_test(inst, t, p_ack[t], p_done[t], p_pass[t], p_gp[t], inst == 1,
              (t == dis_t) ? dis_kind : 0, last);
      if (last) break;
    end
  endtask

  task automatic set_plan(input int t, input int ack, input int dn, input bit ps, input logic [CW-1:0] gp);
    p_ack[t] = ack; p_done[t] = dn; p_pass[t] = ps; p_gp[t] = gp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; ack_s[i] = 1'b0;
      done_s[i] = '0; pass_s[i] = '0; gp_s[i] = '0;
    end
    tick(); tick();
    chk_all_zero(0);
    chk_all_zero(1);
    rst = 1'b0;
    tick();

    // All three tests pass
    for (int t = 0; t < TN; t++) set_plan(t, 2, 10, 1'b1, 32'h0);
    run_seq(0, -1, 0);

    // Stop-on-fail: test 1 fails with gp=7
    set_plan(0, 2, 10, 1'b1, 32'h0);
    set_plan(1, 2, 10, 1'b0, 32'd7);
    set_plan(2, 2, 10, 1'b1, 32'h0);
    run_seq(1, -1, 0);

    // Timeout on test 0 (start pulsed while busy), then done on the timeout cycle
    set_plan(0, 1, 0, 1'b1, 32'h0);
    set_plan(1, 3, 7, 1'b1, 32'h0);
    set_plan(2, 2, TMO, 1'b1, 32'h0);
    run_seq(0, 0, 1);

    // Asynchronous reset in RUN of test 1, then a clean restart
    set_plan(0, 2, 0, 1'b1, 32'h0);
    set_plan(1, 2, 10, 1'b1, 32'h0);
    run_seq(0, 1, 2);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_busy", busy_s[0], 0);
    chk("post_rst_rstn", rstn_s[0], 0);
    for (int t = 0; t < TN; t++) set_plan(t, 1, 4, 1'b1, 32'h0);
    run_seq(0, -1, 0);

    // Randomized plans on both instances
    for (int it = 0; it < 8; it++) begin
      for (int t = 0; t < TN; t++) begin
        d = $urandom_range(1, 24);
        set_plan(t, $urandom_range(1, 3), (d > TMO) ? 0 : d,
                 $urandom_range(0, 3) != 0, $urandom);
      end
      run_seq(it % 2, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
